// File: rtl/acc_dispatcher_queue.sv
// Commit-gated dispatcher queue between the issue stage and one accelerator port.
// Entries are buffered speculatively and marked committed by trans_id. Committed
// entries leave in order from the head. A flush drops every uncommitted entry.
// Load/store counters track dispatched memory ops and can stall dispatch.
//
// Handshakes: each port transfers on a cycle where its valid and ready are both
// high at the rising clock edge. The issue side sees issue_ready_o computed from
// registered state only. The accelerator side sees acc_req_valid_o computed from
// registered state only, so valid never depends on acc_req_ready_i.
module acc_dispatcher_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NR_COMMIT  = 2,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned TRANS_ID_W = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [31:0]                     issue_insn_i,
  input  logic [XLEN-1:0]                 issue_rs1_i,
  input  logic [XLEN-1:0]                 issue_rs2_i,
  input  logic [TRANS_ID_W-1:0]           issue_trans_id_i,
  input  logic [1:0]                      issue_op_i,
  input  logic [NR_COMMIT-1:0]            commit_valid_i,
  input  logic [NR_COMMIT*TRANS_ID_W-1:0] commit_trans_id_i,
  input  logic                            no_st_pending_i,
  output logic                            acc_req_valid_o,
  input  logic                            acc_req_ready_i,
  output logic [31:0]                     acc_req_insn_o,
  output logic [XLEN-1:0]                 acc_req_rs1_o,
  output logic [XLEN-1:0]                 acc_req_rs2_o,
  output logic [TRANS_ID_W-1:0]           acc_req_trans_id_o,
  output logic                            acc_req_st_pend_o,
  input  logic                            acc_load_done_i,
  input  logic                            acc_store_done_i,
  output logic                            no_ld_pending_o,
  output logic                            no_st_pending_o,
  output logic                            cnt_err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  // Payload storage, written only on enqueue
  logic [31:0]           insn_q [DEPTH];
  logic [XLEN-1:0]       rs1_q  [DEPTH];
  logic [XLEN-1:0]       rs2_q  [DEPTH];
  logic [TRANS_ID_W-1:0] tid_q  [DEPTH];
  logic [1:0]            op_q   [DEPTH];

  // Control state
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] cmt_q, cmt_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   kept;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
  logic             cnt_err_q, cnt_err_d;

  logic head_is_load, head_is_store;
  logic pop, enq, enq_cmt;
  logic ld_inc, st_inc;
  logic queued_ld, queued_st;

  assign head_is_load  = (op_q[head_q] == OP_LOAD);
  assign head_is_store = (op_q[head_q] == OP_STORE);

  assign issue_ready_o   = ~&valid_q;
  assign acc_req_valid_o = valid_q[head_q] && cmt_q[head_q] &&
                           !(head_is_load  && (ld_cnt_q == CNT_MAX)) &&
                           !(head_is_store && (st_cnt_q == CNT_MAX));
  assign pop    = acc_req_valid_o && acc_req_ready_i;
  assign enq    = issue_valid_i && issue_ready_o && !flush_i;
  assign ld_inc = pop && head_is_load;
  assign st_inc = pop && head_is_store;

  assign acc_req_insn_o     = insn_q[head_q];
  assign acc_req_rs1_o      = rs1_q[head_q];
  assign acc_req_rs2_o      = rs2_q[head_q];
  assign acc_req_trans_id_o = tid_q[head_q];
  assign acc_req_st_pend_o  = !no_st_pending_i;
  assign cnt_err_o          = cnt_err_q;

  // Does any commit port name the id being enqueued this cycle
  always_comb begin
    enq_cmt = 1'b0;
    for (int p = 0; p < NR_COMMIT; p++) begin
      if (commit_valid_i[p] &&
          (commit_trans_id_i[p*TRANS_ID_W +: TRANS_ID_W] == issue_trans_id_i)) begin
        enq_cmt = 1'b1;
      end
    end
  end

  // Scan queued entries for outstanding loads and stores
  always_comb begin
    queued_ld = 1'b0;
    queued_st = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (valid_q[e] && (op_q[e] == OP_LOAD))  queued_ld = 1'b1;
      if (valid_q[e] && (op_q[e] == OP_STORE)) queued_st = 1'b1;
    end
  end

  assign no_ld_pending_o = !queued_ld && (ld_cnt_q == '0);
  assign no_st_pending_o = !queued_st && (st_cnt_q == '0);

  // Next queue state: commits, then pop, then enqueue, then flush trimming
  always_comb begin
    valid_d = valid_q;
    cmt_d   = cmt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    kept    = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = 0; p < NR_COMMIT; p++) begin
        if (commit_valid_i[p] && valid_q[e] && !cmt_q[e] &&
            (tid_q[e] == commit_trans_id_i[p*TRANS_ID_W +: TRANS_ID_W])) begin
          cmt_d[e] = 1'b1;
        end
      end
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      cmt_d[head_q]   = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      cmt_d[tail_q]   = enq_cmt;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (flush_i) begin
      // Committed entries are a prefix from head, so the new tail sits right after them
      valid_d = valid_d & cmt_d;
      cmt_d   = cmt_d & valid_d;
      for (int e = 0; e < DEPTH; e++) begin
        kept = kept + {{PTR_W{1'b0}}, valid_d[e]};
      end
      tail_d = head_d + kept[PTR_W-1:0];
    end
  end

  // Next counter state: dispatch increments, done decrements, done at zero is an error
  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    st_cnt_d  = st_cnt_q;
    cnt_err_d = cnt_err_q;
    if (ld_inc && !acc_load_done_i) begin
      ld_cnt_d = ld_cnt_q + CNT_W'(1);
    end else if (!ld_inc && acc_load_done_i) begin
      if (ld_cnt_q == '0) cnt_err_d = 1'b1;
      else                ld_cnt_d  = ld_cnt_q - CNT_W'(1);
    end
    if (st_inc && !acc_store_done_i) begin
      st_cnt_d = st_cnt_q + CNT_W'(1);
    end else if (!st_inc && acc_store_done_i) begin
      if (st_cnt_q == '0) cnt_err_d = 1'b1;
      else                st_cnt_d  = st_cnt_q - CNT_W'(1);
    end
  end

  // Control and counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      cmt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      cnt_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      cmt_q     <= cmt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      ld_cnt_q  <= ld_cnt_d;
      st_cnt_q  <= st_cnt_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  // Payload write at tail; contents are qualified by valid_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (enq && !rst_i) begin
      insn_q[tail_q] <= issue_insn_i;
      rs1_q[tail_q]  <= issue_rs1_i;
      rs2_q[tail_q]  <= issue_rs2_i;
      tid_q[tail_q]  <= issue_trans_id_i;
      op_q[tail_q]   <= issue_op_i;
    end
  end

endmodule

// File: tb/tb_acc_dispatcher_queue.sv
// Bench for acc_dispatcher_queue: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_acc_dispatcher_queue;

  localparam int DEPTH = 4;
  localparam int NRC   = 2;
  localparam int CNT_W = 3;
  localparam int XLEN  = 64;
  localparam int TW    = 3;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic            clk, rst, flush;
  logic            issue_valid, issue_ready;
  logic [31:0]     issue_insn;
  logic [XLEN-1:0] issue_rs1, issue_rs2;
  logic [TW-1:0]   issue_tid;
  logic [1:0]      issue_op;
  logic [NRC-1:0]  commit_valid;
  logic [TW-1:0]   c0_id, c1_id;
  logic            no_st_in;
  logic            req_valid, req_ready;
  logic [31:0]     req_insn;
  logic [XLEN-1:0] req_rs1, req_rs2;
  logic [TW-1:0]   req_tid;
  logic            req_st_pend;
  logic            ld_done, st_done;
  logic            no_ld_out, no_st_out, cnt_err;

  acc_dispatcher_queue #(
    .DEPTH(DEPTH), .NR_COMMIT(NRC), .CNT_W(CNT_W), .XLEN(XLEN), .TRANS_ID_W(TW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_insn_i(issue_insn), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .issue_trans_id_i(issue_tid), .issue_op_i(issue_op),
    .commit_valid_i(commit_valid), .commit_trans_id_i({c1_id, c0_id}),
    .no_st_pending_i(no_st_in),
    .acc_req_valid_o(req_valid), .acc_req_ready_i(req_ready),
    .acc_req_insn_o(req_insn), .acc_req_rs1_o(req_rs1), .acc_req_rs2_o(req_rs2),
    .acc_req_trans_id_o(req_tid), .acc_req_st_pend_o(req_st_pend),
    .acc_load_done_i(ld_done), .acc_store_done_i(st_done),
    .no_ld_pending_o(no_ld_out), .no_st_pending_o(no_st_out), .cnt_err_o(cnt_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  typedef struct {
    logic [31:0]     insn;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [TW-1:0]   tid;
    logic [1:0]      op;
    bit              cm;
  } ent_t;

  ent_t          mq[$];
  logic [TW-1:0] disp_log[$];
  int            ld_cnt, st_cnt;
  bit            m_err;
  int            n_vec, n_err;
  int            n_enq, n_pop;
  logic [TW-1:0] next_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    ld_cnt = 0;
    st_cnt = 0;
    m_err  = 1'b0;
  endfunction

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    if (!mq[0].cm) return 1'b0;
    if (mq[0].op == 2'b01 && ld_cnt == MAX) return 1'b0;
    if (mq[0].op == 2'b10 && st_cnt == MAX) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_no_pend(input logic [1:0] op, input int cnt);
    foreach (mq[i]) if (mq[i].op == op) return 1'b0;
    return (cnt == 0);
  endfunction

  function automatic bit id_hit(input logic [TW-1:0] id);
    return (commit_valid[0] && c0_id == id) || (commit_valid[1] && c1_id == id);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  function automatic void model_step();
    bit   v, rdy, li, si;
    ent_t e;
    ent_t keep[$];
    if (rst) begin
      model_reset();
      return;
    end
    v   = m_valid();
    rdy = (mq.size() < DEPTH);
    foreach (mq[i]) if (!mq[i].cm && id_hit(mq[i].tid)) mq[i].cm = 1'b1;
    li = v && req_ready && mq[0].op == 2'b01;
    si = v && req_ready && mq[0].op == 2'b10;
    if (v && req_ready) void'(mq.pop_front());
    if (issue_valid && rdy && !flush) begin
      e.insn = issue_insn; e.rs1 = issue_rs1; e.rs2 = issue_rs2;
      e.tid = issue_tid; e.op = issue_op; e.cm = id_hit(issue_tid);
      mq.push_back(e);
      n_enq++;
    end
    if (flush) begin
      foreach (mq[i]) if (mq[i].cm) keep.push_back(mq[i]);
      mq = keep;
    end
    if (li && !ld_done) ld_cnt++;
    else if (!li && ld_done) begin
      if (ld_cnt == 0) m_err = 1'b1; else ld_cnt--;
    end
    if (si && !st_done) st_cnt++;
    else if (!si && st_done) begin
      if (st_cnt == 0) m_err = 1'b1; else st_cnt--;
    end
  endfunction

  task automatic check_cycle();
    bit v;
    v = m_valid();
    chk("issue_ready", issue_ready, mq.size() < DEPTH);
    chk("req_valid", req_valid, v);
    if (v) begin
      chk("req_insn", req_insn, mq[0].insn);
      chk("req_rs1", req_rs1, mq[0].rs1);
      chk("req_rs2", req_rs2, mq[0].rs2);
      chk("req_tid", req_tid, mq[0].tid);
    end
    chk("st_pend", req_st_pend, !no_st_in);
    chk("no_ld_pending", no_ld_out, m_no_pend(2'b01, ld_cnt));
    chk("no_st_pending", no_st_out, m_no_pend(2'b10, st_cnt));
    chk("cnt_err", cnt_err, m_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit iv, input logic [TW-1:0] tid, input logic [1:0] op,
                        input logic [1:0] cv, input logic [TW-1:0] c0, input logic [TW-1:0] c1,
                        input bit ar, input bit fl);
    rst          = 1'b0;
    issue_valid  = iv;
    issue_tid    = tid;
    issue_op     = op;
    issue_insn   = $urandom;
    issue_rs1    = {$urandom, $urandom};
    issue_rs2    = {$urandom, $urandom};
    commit_valid = cv;
    c0_id        = c0;
    c1_id        = c1;
    req_ready    = ar;
    flush        = fl;
    ld_done      = 1'b0;
    st_done      = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, log dispatches, step the model, cross the edge
  task automatic tick(input bit tchk = 1'b0, input bit er = 1'b0, input bit ev = 1'b0,
                      input logic [TW-1:0] et = '0);
    @(negedge clk);
    check_cycle();
    if (tchk) begin
      chk("tbl_ready", issue_ready, er);
      chk("tbl_valid", req_valid, ev);
      if (ev) chk("tbl_tid", req_tid, et);
    end
    if (req_valid && req_ready) begin
      disp_log.push_back(req_tid);
      n_pop++;
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Drive one randomized cycle; ids stay unique among live entries, commits stay in order
  task automatic rand_cycle(input bit allow_flush);
    logic [TW-1:0] cand[$];
    bit            iv, fl, will_enq;
    int            n;
    logic [1:0]    cv;
    logic [TW-1:0] c0, c1;
    fl = allow_flush && ($urandom_range(0, 39) == 0);
    iv = ($urandom_range(0, 3) != 0);
    foreach (mq[i]) if (mq[i].tid == next_id) iv = 1'b0;
    will_enq = iv && (mq.size() < DEPTH) && !fl;
    foreach (mq[i]) if (!mq[i].cm) cand.push_back(mq[i].tid);
    if (will_enq) cand.push_back(next_id);
    n = $urandom_range(0, 2);
    if (n > cand.size()) n = cand.size();
    cv = 2'b00; c0 = '0; c1 = '0;
    if (n >= 1) begin cv[0] = 1'b1; c0 = cand[0]; end
    if (n == 2) begin
      cv[1] = 1'b1; c1 = cand[1];
    end else if (mq.size() > 0 && mq[0].cm && $urandom_range(0, 3) == 0) begin
      cv[1] = 1'b1; c1 = mq[0].tid;   // stale id of an already committed entry
    end
    set_in(iv, next_id, 2'($urandom_range(0, 2)), cv, c0, c1, 1'($urandom_range(0, 1)), fl);
    ld_done  = (ld_cnt > 0) && ($urandom_range(0, 3) == 0);
    st_done  = (st_cnt > 0) && ($urandom_range(0, 3) == 0);
    no_st_in = 1'($urandom_range(0, 1));
    if (will_enq) next_id = next_id + 1'b1;
    tick();
  endtask

  // Commit everything outstanding and let the queue and counters empty out
  task automatic drain();
    logic [TW-1:0] cand[$];
    logic [1:0]    cv;
    for (int k = 0; k < 200 && (mq.size() > 0 || ld_cnt > 0 || st_cnt > 0); k++) begin
      cand.delete();
      foreach (mq[i]) if (!mq[i].cm) cand.push_back(mq[i].tid);
      cv = 2'b00;
      if (cand.size() >= 1) cv[0] = 1'b1;
      if (cand.size() >= 2) cv[1] = 1'b1;
      set_in(1'b0, '0, 2'b00, cv, (cand.size() >= 1) ? cand[0] : '0,
             (cand.size() >= 2) ? cand[1] : '0, 1'b1, 1'b0);
      ld_done = (ld_cnt > 0);
      st_done = (st_cnt > 0);
      tick();
    end
    if (mq.size() != 0 || ld_cnt != 0 || st_cnt != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d entries left, required 0", mq.size());
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            iv;
    logic [TW-1:0] tid;
    logic [1:0]    op;
    logic [1:0]    cv;
    logic [TW-1:0] c0;
    logic [TW-1:0] c1;
    bit            ar;
    bit            fl;
    bit            er;
    bit            ev;
    logic [TW-1:0] et;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // fill: fill to full uncommitted, reject while full, commit-then-pop, same-cycle commit
    tbl[0]  = '{1'b1, 3'd0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 3'd1, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 3'd2, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 3'd3, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[4]  = '{1'b0, 3'd0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{1'b1, 3'd4, 2'b00, 2'b01, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[6]  = '{1'b0, 3'd0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[7]  = '{1'b0, 3'd0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[8]  = '{1'b0, 3'd0, 2'b00, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[9]  = '{1'b0, 3'd0, 2'b00, 2'b01, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1};
    tbl[10] = '{1'b0, 3'd0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2};
    tbl[11] = '{1'b0, 3'd0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3};
    tbl[12] = '{1'b1, 3'd5, 2'b00, 2'b10, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[13] = '{1'b0, 3'd0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5};
    tbl[14] = '{1'b0, 3'd0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5};
    tbl[15] = '{1'b0, 3'd0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
  end

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0; n_err = 0; n_enq = 0; n_pop = 0; next_id = '0;
    no_st_in = 1'b1;
    set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // reset state
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_no_ld", no_ld_out, 1'b1);
    chk("rst_no_st", no_st_out, 1'b1);
    chk("rst_cnt_err", cnt_err, 1'b0);

    // vector table
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].iv, tbl[i].tid, tbl[i].op, tbl[i].cv, tbl[i].c0, tbl[i].c1,
             tbl[i].ar, tbl[i].fl);
      tick(1'b1, tbl[i].er, tbl[i].ev, tbl[i].et);
    end

    // flush keeps only the committed prefix and drops the uncommitted load
    set_in(1'b1, 3'd1, 2'b00, 2'b00, '0, '0, 1'b0, 1'b0); tick();
    set_in(1'b1, 3'd2, 2'b00, 2'b00, '0, '0, 1'b0, 1'b0); tick();
    set_in(1'b1, 3'd3, 2'b01, 2'b00, '0, '0, 1'b0, 1'b0); tick();
    chk("flush_no_ld_before", no_ld_out, 1'b0);
    set_in(1'b0, '0, 2'b00, 2'b11, 3'd1, 3'd2, 1'b0, 1'b1); tick();
    chk("flush_no_ld_after", no_ld_out, 1'b1);
    disp_log.delete();
    set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0);
    repeat (6) tick();
    chk("flush_disp_count", disp_log.size(), 2);
    if (disp_log.size() >= 2) begin
      chk("flush_disp_first", disp_log[0], 3'd1);
      chk("flush_disp_second", disp_log[1], 3'd2);
    end

    // load counter saturation stalls dispatch; one done releases it
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 3'(i), 2'b01, 2'b01, 3'(i), '0, 1'b1, 1'b0);
      tick();
    end
    set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0); tick();
    set_in(1'b1, 3'd7, 2'b01, 2'b01, 3'd7, '0, 1'b1, 1'b0); tick();
    chk("ld_stall_a", req_valid, 1'b0);
    set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0); tick();
    chk("ld_stall_b", req_valid, 1'b0);
    chk("ld_stall_no_ld", no_ld_out, 1'b0);
    set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0);
    ld_done = 1'b1;
    tick();
    chk("ld_release", req_valid, 1'b1);
    set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 7; i++) begin
      set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b0, 1'b0);
      ld_done = 1'b1;
      tick();
    end
    chk("ld_drained_no_ld", no_ld_out, 1'b1);

    // store done with an empty counter is an error that holds until reset
    set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b0, 1'b0);
    st_done = 1'b1;
    tick();
    chk("st_err_set", cnt_err, 1'b1);
    chk("st_err_no_st", no_st_out, 1'b1);
    set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b0, 1'b0); tick();
    chk("st_err_sticky", cnt_err, 1'b1);
    rst = 1'b1;
    tick();
    set_in(1'b0, '0, 2'b00, 2'b00, '0, '0, 1'b0, 1'b0);
    chk("st_err_cleared", cnt_err, 1'b0);

    // random traffic without flush: every enqueued request must come out in order
    n_enq = 0; n_pop = 0;
    for (int i = 0; i < 300; i++) rand_cycle(1'b0);
    drain();
    chk("no_loss", n_pop, n_enq);

    // random traffic with occasional flushes
    for (int i = 0; i < 300; i++) rand_cycle(1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
